// File: rtl/inst_cache_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_cache_if
// Description : Bundle of fetcher-side and memory-controller-side signals
//               of the instruction cache.
//   Fetcher side   : wrong_jump, if_req, if_pc -> cache
//                    inst_valid, inst, inst_pc <- cache
//   Memory side    : fetch_enable, inst_addr <- cache
//                    mem_valid, mem_data -> cache
//   Modports       : slave  - the cache itself
//                    master - the environment (fetcher + memory controller)
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_cache_if;
  logic        wrong_jump;
  logic        if_req;
  logic [31:0] if_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_enable;
  logic [31:0] inst_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  modport slave (
    input  wrong_jump, if_req, if_pc, mem_valid, mem_data,
    output inst_valid, inst, inst_pc, fetch_enable, inst_addr
  );

  modport master (
    output wrong_jump, if_req, if_pc, mem_valid, mem_data,
    input  inst_valid, inst, inst_pc, fetch_enable, inst_addr
  );
endinterface
`default_nettype wire

// File: rtl/inst_cache.sv
`default_nettype none
// ============================================================================
// Module      : inst_cache
// Description : Direct-mapped, read-only, one-word-per-line instruction cache.
//               Hits return one cycle after the request; misses issue a single
//               word fetch, fill the line and forward the word unless a
//               mispredict arrived while the fill was outstanding.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               rdy   - global enable; all state holds while low
//               bus   - inst_cache_if.slave (fetcher + memory controller)
// Parameters  : INDEX_BITS - line index width, 2**INDEX_BITS lines
// Revision    : 1.0 - initial release
// ============================================================================
module inst_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  inst_cache_if.slave bus
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;

  logic [LINES-1:0] r_line_valid;
  logic [TAG_W-1:0] r_tag_mem  [LINES];
  logic [31:0]      r_data_mem [LINES];

  logic        r_inst_valid,   w_inst_valid_nxt;
  logic [31:0] r_inst,         w_inst_nxt;
  logic [31:0] r_inst_pc,      w_inst_pc_nxt;
  logic        r_fetch_enable, w_fetch_enable_nxt;
  logic [31:0] r_inst_addr,    w_inst_addr_nxt;   // doubles as the miss pc
  logic        r_flushed,      w_flushed_nxt;
  logic        w_fill;

  logic [INDEX_BITS-1:0] w_req_idx, w_fill_idx;
  logic [TAG_W-1:0]      w_req_tag, w_fill_tag;
  logic                  w_hit;
  logic                  unused_pc_bits;

  assign w_req_idx  = bus.if_pc[INDEX_BITS+1:2];
  assign w_req_tag  = bus.if_pc[31:INDEX_BITS+2];
  assign w_fill_idx = r_inst_addr[INDEX_BITS+1:2];
  assign w_fill_tag = r_inst_addr[31:INDEX_BITS+2];
  assign w_hit      = r_line_valid[w_req_idx] && (r_tag_mem[w_req_idx] == w_req_tag);

  // byte offset within the word is irrelevant to a word cache
  assign unused_pc_bits = ^bus.if_pc[1:0];

  always_comb begin
    w_state_nxt        = r_state;
    w_inst_valid_nxt   = 1'b0;
    w_inst_nxt         = r_inst;
    w_inst_pc_nxt      = r_inst_pc;
    w_fetch_enable_nxt = r_fetch_enable;
    w_inst_addr_nxt    = r_inst_addr;
    w_flushed_nxt      = r_flushed;
    w_fill             = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!bus.wrong_jump && bus.if_req) begin
          if (w_hit) begin
            w_inst_valid_nxt = 1'b1;
            w_inst_nxt       = r_data_mem[w_req_idx];
            w_inst_pc_nxt    = {bus.if_pc[31:2], 2'b00};
          end else begin
            w_fetch_enable_nxt = 1'b1;
            w_inst_addr_nxt    = {bus.if_pc[31:2], 2'b00};
            w_state_nxt        = S_MISS;
          end
        end
      end

      S_MISS: begin
        // A mispredict cannot cancel the fetch; remember it so the word is
        // written into the line but not handed to the fetcher.
        if (bus.wrong_jump) begin
          w_flushed_nxt = 1'b1;
        end
        if (bus.mem_valid) begin
          w_fill             = 1'b1;
          w_fetch_enable_nxt = 1'b0;
          w_flushed_nxt      = 1'b0;
          w_state_nxt        = S_IDLE;
          if (!r_flushed && !bus.wrong_jump) begin
            w_inst_valid_nxt = 1'b1;
            w_inst_nxt       = bus.mem_data;
            w_inst_pc_nxt    = r_inst_addr;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_line_valid   <= '0;
      r_inst_valid   <= 1'b0;
      r_inst         <= '0;
      r_inst_pc      <= '0;
      r_fetch_enable <= 1'b0;
      r_inst_addr    <= '0;
      r_flushed      <= 1'b0;
    end else if (rdy) begin
      r_state        <= w_state_nxt;
      r_inst_valid   <= w_inst_valid_nxt;
      r_inst         <= w_inst_nxt;
      r_inst_pc      <= w_inst_pc_nxt;
      r_fetch_enable <= w_fetch_enable_nxt;
      r_inst_addr    <= w_inst_addr_nxt;
      r_flushed      <= w_flushed_nxt;
      if (w_fill) begin
        r_line_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (rdy && w_fill) begin
      r_tag_mem[w_fill_idx]  <= w_fill_tag;
      r_data_mem[w_fill_idx] <= bus.mem_data;
    end
  end

  assign bus.inst_valid   = r_inst_valid;
  assign bus.inst         = r_inst;
  assign bus.inst_pc      = r_inst_pc;
  assign bus.fetch_enable = r_fetch_enable;
  assign bus.inst_addr    = r_inst_addr;

endmodule
`default_nettype wire

// File: tb/tb_inst_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_cache
// Description : Self-checking bench for inst_cache. Directed scenarios plus a
//               randomized request stream compared against a line model
//               that stores the full word address and data per index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_cache;

  localparam int IB   = 6;
  localparam int NONE = 99;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;

  inst_cache_if bus();

  inst_cache #(.INDEX_BITS(IB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference: per index, the word address held and its data
  logic [29:0] m_word [int];
  logic [31:0] m_data [int];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % (1 << IB));
  endfunction

  function automatic logic model_hit(input logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return m_word.exists(i) && (m_word[i] == pc[31:2]);
  endfunction

  // Called at a negedge with the cache idle. For a miss the memory answers
  // after 'delay' wait cycles; wrong_jump is pulsed in wait cycle wj_at
  // (wj_at == delay means together with mem_valid, > delay means never).
  task automatic request(input logic [31:0] pc, input int delay, input int wj_at,
                         input logic [31:0] data);
    int   i;
    logic exp_valid;
    logic [31:0] al;
    i  = idx_of(pc);
    al = {pc[31:2], 2'b00};
    if (model_hit(pc)) begin
      bus.if_req = 1'b1; bus.if_pc = pc;
      @(negedge clk);
      bus.if_req = 1'b0;
      check_val("hit_valid", 32'(bus.inst_valid), 32'd1);
      check_val("hit_inst", bus.inst, m_data[i]);
      check_val("hit_pc", bus.inst_pc, al);
      check_val("hit_fetch_en", 32'(bus.fetch_enable), 32'd0);
    end else begin
      bus.if_req = 1'b1; bus.if_pc = pc;
      @(negedge clk);
      bus.if_req = 1'b0;
      check_val("miss_fetch_en", 32'(bus.fetch_enable), 32'd1);
      check_val("miss_addr", bus.inst_addr, al);
      check_val("miss_valid", 32'(bus.inst_valid), 32'd0);
      exp_valid = 1'b1;
      for (int c = 0; c < delay; c++) begin
        bus.wrong_jump = (c == wj_at);
        if (c == wj_at) exp_valid = 1'b0;
        @(negedge clk);
        bus.wrong_jump = 1'b0;
        check_val("wait_fetch_en", 32'(bus.fetch_enable), 32'd1);
        check_val("wait_addr", bus.inst_addr, al);
        check_val("wait_valid", 32'(bus.inst_valid), 32'd0);
      end
      bus.mem_valid = 1'b1; bus.mem_data = data;
      bus.wrong_jump = (wj_at == delay);
      if (wj_at == delay) exp_valid = 1'b0;
      @(negedge clk);
      bus.mem_valid = 1'b0; bus.wrong_jump = 1'b0;
      check_val("fill_fetch_en", 32'(bus.fetch_enable), 32'd0);
      check_val("fill_valid", 32'(bus.inst_valid), 32'(exp_valid));
      if (exp_valid) begin
        check_val("fill_inst", bus.inst, data);
        check_val("fill_pc", bus.inst_pc, al);
      end
      m_word[i] = pc[31:2];
      m_data[i] = data;
    end
  endtask

  // Request together with a mispredict in IDLE: nothing may happen.
  task automatic wj_request(input logic [31:0] pc);
    bus.if_req = 1'b1; bus.if_pc = pc; bus.wrong_jump = 1'b1;
    @(negedge clk);
    bus.if_req = 1'b0; bus.wrong_jump = 1'b0;
    check_val("wj_valid", 32'(bus.inst_valid), 32'd0);
    check_val("wj_fetch_en", 32'(bus.fetch_enable), 32'd0);
  endtask

  initial begin
    logic [31:0] pc;
    rst_n = 1'b0; rdy = 1'b1;
    bus.wrong_jump = 1'b0; bus.if_req = 1'b0; bus.if_pc = '0;
    bus.mem_valid = 1'b0; bus.mem_data = '0;
    repeat (2) @(negedge clk);
    check_val("rst_valid", 32'(bus.inst_valid), 32'd0);
    check_val("rst_fetch_en", 32'(bus.fetch_enable), 32'd0);
    check_val("rst_inst", bus.inst, 32'd0);
    check_val("rst_pc", bus.inst_pc, 32'd0);
    check_val("rst_addr", bus.inst_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // cold miss, hit on an unaligned pc of the same word
    request(32'h100, 1, NONE, 32'h00500093);
    request(32'h102, 0, NONE, 32'h0);
    // conflict on index 0
    request(32'h200, 2, NONE, 32'h00a00113);
    request(32'h100, 0, NONE, 32'h00500093);
    // mispredict two cycles after the miss issue, then a hit
    request(32'h144, 3, 1, 32'h12345678);
    request(32'h144, 0, NONE, 32'h0);
    @(negedge clk);

    // rdy stall with a hit request
    rdy = 1'b0; bus.if_req = 1'b1; bus.if_pc = 32'h144;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("stall_hit_valid", 32'(bus.inst_valid), 32'd0);
    end
    rdy = 1'b1;
    @(negedge clk);
    bus.if_req = 1'b0;
    check_val("stall_hit_result", 32'(bus.inst_valid), 32'd1);
    check_val("stall_hit_inst", bus.inst, 32'h12345678);
    check_val("stall_hit_pc", bus.inst_pc, 32'h144);

    // rdy stall with mem_valid during a miss
    bus.if_req = 1'b1; bus.if_pc = 32'h408;
    @(negedge clk);
    bus.if_req = 1'b0;
    check_val("stall_miss_fetch_en", 32'(bus.fetch_enable), 32'd1);
    rdy = 1'b0; bus.mem_valid = 1'b1; bus.mem_data = 32'hcafe0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("stall_fill_fetch_en", 32'(bus.fetch_enable), 32'd1);
      check_val("stall_fill_valid", 32'(bus.inst_valid), 32'd0);
    end
    rdy = 1'b1;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    check_val("stall_fill_result", 32'(bus.inst_valid), 32'd1);
    check_val("stall_fill_inst", bus.inst, 32'hcafe0001);
    check_val("stall_fill_pc", bus.inst_pc, 32'h408);
    check_val("stall_fill_drop", 32'(bus.fetch_enable), 32'd0);
    m_word[idx_of(32'h408)] = 30'(32'h408 >> 2);
    m_data[idx_of(32'h408)] = 32'hcafe0001;

    // mispredict with a hit and with a miss request in IDLE
    wj_request(32'h144);
    wj_request(32'h944);
    // stray mem_valid in IDLE must not touch the array
    bus.mem_valid = 1'b1; bus.mem_data = 32'hdeadbeef;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    request(32'h408, 0, NONE, 32'h0);
    request(32'h100, 0, NONE, 32'h0);

    // asynchronous reset while a miss is outstanding
    bus.if_req = 1'b1; bus.if_pc = 32'h5c0;
    @(negedge clk);
    bus.if_req = 1'b0;
    check_val("arst_pre_fetch_en", 32'(bus.fetch_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_fetch_en", 32'(bus.fetch_enable), 32'd0);
    check_val("arst_valid", 32'(bus.inst_valid), 32'd0);
    check_val("arst_addr", bus.inst_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_word.delete();
    m_data.delete();
    @(negedge clk);
    request(32'h5c0, 1, NONE, 32'h0badf00d);
    request(32'h144, 0, NONE, 32'h77777777);

    // randomized stream over a few tags and indices
    for (int n = 0; n < 300; n++) begin
      pc = ($urandom_range(0, 3) << (IB + 2)) | ($urandom_range(0, 7) << 2)
         | $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) begin
        wj_request(pc);
      end else begin
        request(pc, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), $urandom);
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache between the instruction fetcher and the memory controller.
- On a hit it returns a 32-bit instruction one cycle after the request.
- On a miss it raises a word fetch to the memory controller, fills the line when that word arrives, and delivers it to the fetcher.
- It discards a pending response on a branch mispredict (wrong_jump) but still completes any in-flight fill.

Parameters:
INDEX_BITS, 6, line-index width; the cache holds 2^INDEX_BITS one-word lines.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
rdy  in  1  global enable; when low, all state and outputs hold
wrong_jump  in  1  mispredict flush
if_req  in  1  fetcher requests the instruction at if_pc
if_pc  in  32  fetch address; bits [1:0] are ignored
inst_valid  out  1  one-cycle pulse: inst and inst_pc are valid
inst  out  32  returned instruction
inst_pc  out  32  word-aligned address of inst
fetch_enable  out  1  miss request to the memory controller
inst_addr  out  32  word-aligned miss address
mem_valid  in  1  memory controller word-ready pulse
mem_data  in  32  fetched word, little-endian assembled

Behaviour:
- Address split: index = if_pc[INDEX_BITS+1:2]; tag = if_pc[31:INDEX_BITS+2].
- Line storage: per line, a valid bit, a tag and a 32-bit data word.
- Reset (rst_n=0, asynchronous): all valid bits are 0 and the state is IDLE. inst_valid=0, fetch_enable=0, inst=0, inst_pc=0, inst_addr=0. The flushed flag is 0. Tag and data arrays need no reset.
- rdy=0: no register changes, including mem_valid capture. The memory controller also freezes on rdy, so no data is lost.
- State IDLE:
  - inst_valid defaults to 0 every cycle unless set below.
  - wrong_jump=1: no lookup, inst_valid<=0.
  - if_req=1, hit (line valid and tag equal): next cycle inst_valid=1, inst=line data, inst_pc={if_pc[31:2],2'b00}. Back-to-back hits give one result per cycle.
  - if_req=1, miss: fetch_enable<=1, inst_addr<={if_pc[31:2],2'b00}, latch the miss pc, go to MISS. inst_valid=0.
- State MISS:
  - fetch_enable and inst_addr are held stable. if_req and if_pc are ignored; the fetcher must hold or re-request.
  - wrong_jump=1 sets flushed<=1. The fill still completes, because the memory controller cannot abort a fetch.
  - mem_valid=1: write the line (valid=1, tag, data=mem_data) and set fetch_enable<=0.
    - If flushed=0 and wrong_jump=0 in this cycle: inst_valid<=1, inst<=mem_data, inst_pc<=miss pc.
    - Otherwise inst_valid<=0.
    - In both cases clear flushed and go to IDLE.
- fetch_enable drops on the same edge that samples mem_valid. The memory controller then sees it low during its post-fetch stall cycle, so no duplicate fetch occurs.
- A new miss may be issued from the cycle after the return to IDLE.
- mem_valid outside MISS is ignored; no array write occurs.
- Aliasing: a fill overwrites the line regardless of its previous contents. There is no write port from the data side and no coherency with stores (self-modifying code is unsupported).
- Only one outstanding miss exists at a time.

Test Plan:
- Reset mid-MISS: fetch_enable=1, then rst_n=0 -> fetch_enable=0 and inst_valid=0 immediately (asynchronous). A subsequent request to the same pc misses again.
- Cold miss then hit: if_req, if_pc=0x100 -> next cycle fetch_enable=1, inst_addr=0x100. mem_valid with mem_data=0x00500093 -> next cycle inst_valid=1, inst=0x00500093, inst_pc=0x100, fetch_enable=0. Re-request 0x102 -> inst_valid one cycle later with the same data and inst_pc=0x100; fetch_enable stays 0.
- Conflict: fill 0x100, then request 0x200 (same index when INDEX_BITS=6) -> miss with inst_addr=0x200. After fill with 0x00a00113, a request to 0x100 misses again.
- Mispredict during miss: wrong_jump pulsed two cycles after the miss issue -> fetch_enable held until mem_valid, no inst_valid pulse. A later request to the same pc hits in one cycle.
- rdy stall: rdy=0 for 3 cycles, coinciding with a hit request and a mem_valid -> outputs frozen. Results appear only after rdy returns high, values unchanged.
- wrong_jump concurrent with a hit request in IDLE -> inst_valid stays 0 and no fetch_enable is raised.
